stack_pointer_pro: RTL and testbench
====================================

# stack_pointer_pro

Parametrised stack-pointer register for the CPU address bus: a WIDTH-bit up/down counter, loadable from the bus, with a registered tri-state read-back path. It adds configurable stack bounds with sticky overflow/underflow faults and an offset read mode (SP + signed displacement) for frame-relative addressing. It sits beside the program counter and address registers on `abus`, driven by active-low control lines from the control-word decoder.

## Interface

Parameters:
- `WIDTH`, 16: counter and bus width (8..32).
- `OFF_W`, 8: width of the signed displacement input.
- `RESET_VALUE`, `{WIDTH{1'b1}}`: SP value after reset (top of stack).
- `LIMIT_LO`, 0: lowest legal SP value.
- `LIMIT_HI`, `{WIDTH{1'b1}}`: highest legal SP value.

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous active-high reset.
- `loadn` in 1: active-low; load SP from `abus`.
- `cupn` in 1: active-low; increment SP.
- `cdownn` in 1: active-low; decrement SP.
- `outn` in 1: active-low; drive the output latch onto `abus`.
- `offsn` in 1: active-low; the output latch captures SP + sign-extended `offset` instead of SP.
- `offset` in OFF_W: signed displacement.
- `fault_clr` in 1: active-high; clears the sticky fault flags.
- `abus` inout WIDTH: shared address bus; high-Z unless `outn` = 0.
- `sp` out WIDTH: current counter value, for debug and the monitor.
- `at_lo` out 1: SP == LIMIT_LO.
- `at_hi` out 1: SP == LIMIT_HI.
- `ovf` out 1: sticky overflow fault.
- `unf` out 1: sticky underflow fault.
- `bus_err` out 1: sticky load/output conflict fault.

## Operation

- Reset values: SP = RESET_VALUE, output latch = RESET_VALUE, `ovf`/`unf`/`bus_err` = 0. `abus` is high-Z when `outn` = 1.
- Action priority each edge:
  - `reset` overrides everything.
  - Load (`loadn` = 0) next.
  - Count: up when `cupn` = 0 and `cdownn` = 1; down when `cdownn` = 0 and `cupn` = 1.
  - `cupn` = `cdownn` = 0 is a hold, with no fault.
- Load: SP takes `abus` unconditionally, even outside the limits. Loading does not touch the fault flags.
- Increment with SP == LIMIT_HI: SP holds and `ovf` sets.
- Decrement with SP == LIMIT_LO: SP holds and `unf` sets.
- No wrap-around ever occurs through counting.
- Out-of-window SP (reachable only by load): counting proceeds modulo 2^WIDTH. The limit checks use equality only.
- Conflict: `loadn` = 0 with `outn` = 0 suppresses the load, holds SP and sets `bus_err`.
- Output latch:
  - Captures every rising edge.
  - Captures SP when `offsn` = 1, otherwise (SP + sext(`offset`)) mod 2^WIDTH.
  - Always captures the SP value before that edge's update.
- `fault_clr`: clears all three flags. A fault raised in the same cycle wins; the flag stays 1.
- `at_lo` and `at_hi` are combinational from SP.

## Timing

- Load, count and flag updates take effect at the edge where the control is sampled. The new SP is visible on `sp` and `at_*` one cycle later.
- Read-back latency is 1 cycle. `abus` in cycle n+1 shows SP (or SP+offset) as of cycle n.
- Push/pop idiom: `outn` = 0 and `cdownn` = 0 in the same cycle drives the pre-decrement value, matching a post-decrement push.
- `abus` enable is combinational from `outn`, with no registered turn-around.
- Reset asserted mid-sequence discards any pending action. Controls are ignored in the reset cycle.

## Structure

- Shared package `sp_pkg`: the control-action enum (HOLD, LOAD, INC, DEC, CONFLICT) and the default WIDTH/OFF_W constants, shared with the control decoder.
- Sub-module `sp_udcounter`: a parametrised synchronous up/down counter with load, limit-saturation and `ovf`/`unf` strobe outputs.
- The top level holds:
  - the action decode;
  - the sticky flags;
  - the output latch with offset adder;
  - the tri-state driver.

## Test plan

- Reset to SP = 0xFFFF, then three cycles of `cdownn` = 0 → SP = 0xFFFC; `outn` = 0 next cycle → `abus` = 0xFFFC.
- Load 0x0002 from the bus, then four decrements with LIMIT_LO = 0 → SP = 0x0000, `unf` = 1 after the third; `fault_clr` → `unf` = 0.
- SP = 0xFFFF, `cupn` = 0 → SP holds and `ovf` = 1. `cupn` = `cdownn` = 0 → SP holds with no new fault.
- SP = 0x1000, `offset` = 0x80 (−128), `offsn` = 0, `outn` = 0 → `abus` = 0x0F80 one cycle later. With `offset` = 0x7F → 0x107F.
- `loadn` = 0 and `outn` = 0 together → SP unchanged and `bus_err` = 1. `reset` in the same cycle as a load of 0x1234 → SP = 0xFFFF and all flags 0.
- WIDTH = 8, LIMIT_LO = 0x10, LIMIT_HI = 0xF0: decrement from 0x10 → holds and `unf` = 1. Load 0x05, then decrement → 0x04 with no fault.

Source files
------------

// File: rtl/stack_pointer_pro_pkg.sv
// Shared definitions for the stack-pointer register and its control decoder.
// Holds the per-edge action encoding and the default bus/displacement widths.
package sp_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_OFF_W = 8;

    typedef enum logic [2:0] {
        HOLD,
        LOAD,
        INC,
        DEC,
        CONFLICT
    } sp_action_e;

    // Load outranks counting; a load while the latch drives the bus is a conflict.
    function automatic sp_action_e decode_action(input logic loadn, input logic outn,
                                                 input logic cupn, input logic cdownn);
        if (!loadn)               return outn ? LOAD : CONFLICT;
        else if (!cupn && cdownn) return INC;
        else if (cupn && !cdownn) return DEC;
        else                      return HOLD;
    endfunction

endpackage

// File: rtl/stack_pointer_pro_if.sv
// Control lines and status outputs of the stack-pointer register.
// The master drives the active-low controls; the slave is the register itself.
interface stack_pointer_pro_if
    import sp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OFF_W = DEF_OFF_W
);
    logic             loadn;
    logic             cupn;
    logic             cdownn;
    logic             outn;
    logic             offsn;
    logic [OFF_W-1:0] offset;
    logic             fault_clr;

    logic [WIDTH-1:0] sp;
    logic             at_lo;
    logic             at_hi;
    logic             ovf;
    logic             unf;
    logic             bus_err;

    modport master (
        output loadn, cupn, cdownn, outn, offsn, offset, fault_clr,
        input  sp, at_lo, at_hi, ovf, unf, bus_err
    );

    modport slave (
        input  loadn, cupn, cdownn, outn, offsn, offset, fault_clr,
        output sp, at_lo, at_hi, ovf, unf, bus_err
    );
endinterface

// File: rtl/stack_pointer_pro_udcounter.sv
// Synchronous up/down counter with load and saturation at equality limits.
// The hit strobes flag a count request that was refused at a limit.
module sp_udcounter
    import sp_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1,
    parameter logic [WIDTH-1:0] LIMIT_LO    = '0,
    parameter logic [WIDTH-1:0] LIMIT_HI    = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  sp_action_e       action,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             ovf_hit,
    output logic             unf_hit
);

    assign ovf_hit = (action == INC) && (count == LIMIT_HI);
    assign unf_hit = (action == DEC) && (count == LIMIT_LO);

    // Out-of-window values never match a limit, so they count modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else begin
            case (action)
                LOAD:    count <= load_value;
                INC:     if (!ovf_hit) count <= count + 1'b1;
                DEC:     if (!unf_hit) count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stack_pointer_pro.sv
// Stack-pointer register: bounded up/down counter, sticky faults, and a
// registered (optionally SP-relative) read-back latch driven onto abus.
module stack_pointer_pro
    import sp_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      OFF_W       = DEF_OFF_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1,
    parameter logic [WIDTH-1:0] LIMIT_LO    = '0,
    parameter logic [WIDTH-1:0] LIMIT_HI    = '1
) (
    input  logic              clk,
    input  logic              reset,
    stack_pointer_pro_if.slave bus,
    inout  wire [WIDTH-1:0]   abus
);

    sp_action_e              action;
    logic [WIDTH-1:0]        sp_q;
    logic                    ovf_hit;
    logic                    unf_hit;
    logic signed [OFF_W-1:0] off_s;
    logic [WIDTH-1:0]        off_ext;
    logic [WIDTH-1:0]        out_latch;
    logic                    ovf_q;
    logic                    unf_q;
    logic                    bus_err_q;

    always_comb action = decode_action(bus.loadn, bus.outn, bus.cupn, bus.cdownn);

    sp_udcounter #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .LIMIT_LO    (LIMIT_LO),
        .LIMIT_HI    (LIMIT_HI)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .action     (action),
        .load_value (abus),
        .count      (sp_q),
        .ovf_hit    (ovf_hit),
        .unf_hit    (unf_hit)
    );

    assign off_s   = bus.offset;
    assign off_ext = WIDTH'(off_s);

    // A fault raised on the same edge as fault_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            bus_err_q <= 1'b0;
            out_latch <= RESET_VALUE;
        end else begin
            ovf_q     <= ovf_hit | (ovf_q & ~bus.fault_clr);
            unf_q     <= unf_hit | (unf_q & ~bus.fault_clr);
            bus_err_q <= (action == CONFLICT) | (bus_err_q & ~bus.fault_clr);
            out_latch <= bus.offsn ? sp_q : sp_q + off_ext;
        end
    end

    assign abus = bus.outn ? 'z : out_latch;

    assign bus.sp      = sp_q;
    assign bus.at_lo   = (sp_q == LIMIT_LO);
    assign bus.at_hi   = (sp_q == LIMIT_HI);
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_stack_pointer_pro.sv
// Scoreboard bench for stack_pointer_pro: a 16-bit default instance and an
// 8-bit windowed instance share one control stream against a reference model.
module tb_stack_pointer_pro;

    typedef struct {
        bit          known;
        int unsigned sp;
        bit          at_lo;
        bit          at_hi;
        bit          ovf;
        bit          unf;
        bit          berr;
        bit          bus_chk;
        int unsigned bus;
    } obs_t;

    logic clk;
    logic reset;
    logic loadn, cupn, cdownn, outn, offsn, fault_clr;
    logic [7:0]  offset;
    logic        drv;
    logic [15:0] drv_a;
    logic [7:0]  drv_b;
    wire  [15:0] abus_a;
    wire  [7:0]  abus_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    obs_t qa[$];
    obs_t qb[$];

    // Reference model state, index 0 = 16-bit instance, 1 = 8-bit instance
    bit          m_known[2];
    int unsigned m_sp[2];
    int unsigned m_lat[2];
    bit          m_ovf[2];
    bit          m_unf[2];
    bit          m_berr[2];

    stack_pointer_pro_if #(.WIDTH(16), .OFF_W(8)) ifa ();
    stack_pointer_pro_if #(.WIDTH(8),  .OFF_W(8)) ifb ();

    assign ifa.loadn = loadn;  assign ifb.loadn = loadn;
    assign ifa.cupn = cupn;    assign ifb.cupn = cupn;
    assign ifa.cdownn = cdownn; assign ifb.cdownn = cdownn;
    assign ifa.outn = outn;    assign ifb.outn = outn;
    assign ifa.offsn = offsn;  assign ifb.offsn = offsn;
    assign ifa.offset = offset; assign ifb.offset = offset;
    assign ifa.fault_clr = fault_clr; assign ifb.fault_clr = fault_clr;

    assign abus_a = drv ? drv_a : 'z;
    assign abus_b = drv ? drv_b : 'z;

    stack_pointer_pro #(
        .WIDTH(16), .OFF_W(8), .RESET_VALUE(16'hFFFF),
        .LIMIT_LO(16'h0000), .LIMIT_HI(16'hFFFF)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa), .abus(abus_a));

    stack_pointer_pro #(
        .WIDTH(8), .OFF_W(8), .RESET_VALUE(8'hFF),
        .LIMIT_LO(8'h10), .LIMIT_HI(8'hF0)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb), .abus(abus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned mask_of(input int d);
        return (d == 0) ? 32'hFFFF : 32'hFF;
    endfunction
    function automatic int unsigned lo_of(input int d);
        return (d == 0) ? 32'h0000 : 32'h10;
    endfunction
    function automatic int unsigned hi_of(input int d);
        return (d == 0) ? 32'hFFFF : 32'hF0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe(input int d, input bit oe);
        obs_t o;
        o.known   = m_known[d];
        o.sp      = m_sp[d];
        o.at_lo   = (m_sp[d] == lo_of(d));
        o.at_hi   = (m_sp[d] == hi_of(d));
        o.ovf     = m_ovf[d];
        o.unf     = m_unf[d];
        o.berr    = m_berr[d];
        o.bus_chk = oe && m_known[d];
        o.bus     = m_lat[d];
        return o;
    endfunction

    task automatic model_step(input int d, input bit r, ld, up, dn, oe, ofs,
                              input logic [7:0] off, input bit clr, input logic [15:0] ldv);
        int unsigned msk;
        bit ovf_set, unf_set, berr_set;
        msk = mask_of(d);
        ovf_set = 0; unf_set = 0; berr_set = 0;
        if (r) begin
            m_known[d] = 1;
            m_sp[d] = msk; m_lat[d] = msk;
            m_ovf[d] = 0; m_unf[d] = 0; m_berr[d] = 0;
        end else if (m_known[d]) begin
            m_lat[d] = ofs ? (m_sp[d] + int'($signed(off))) & msk : m_sp[d];
            if (ld && oe)                berr_set = 1;
            else if (ld)                 m_sp[d] = 32'(ldv) & msk;
            else if (up && !dn) begin
                if (m_sp[d] == hi_of(d)) ovf_set = 1;
                else                     m_sp[d] = (m_sp[d] + 1) & msk;
            end else if (dn && !up) begin
                if (m_sp[d] == lo_of(d)) unf_set = 1;
                else                     m_sp[d] = (m_sp[d] - 1) & msk;
            end
            m_ovf[d]  = ovf_set  | (m_ovf[d]  & !clr);
            m_unf[d]  = unf_set  | (m_unf[d]  & !clr);
            m_berr[d] = berr_set | (m_berr[d] & !clr);
        end
    endtask

    // Arguments are active-high intents; pins are driven inverted where active-low.
    task automatic cyc(input bit r, ld, up, dn, oe, ofs, input logic [7:0] off,
                       input bit clr, input logic [15:0] ldv);
        @(negedge clk);
        reset = r; loadn = !ld; cupn = !up; cdownn = !dn; outn = !oe;
        offsn = !ofs; offset = off; fault_clr = clr;
        drv = ld && !oe; drv_a = ldv; drv_b = ldv[7:0];
        qa.push_back(observe(0, oe));
        qb.push_back(observe(1, oe));
        for (int d = 0; d < 2; d++) model_step(d, r, ld, up, dn, oe, ofs, off, clr, ldv);
    endtask

    always @(negedge clk) begin
        obs_t o;
        #3;
        if (qa.size() > 0) begin
            o = qa.pop_front();
            if (o.known) begin
                check("a.sp", 32'(ifa.sp), o.sp);
                check("a.at_lo", 32'(ifa.at_lo), 32'(o.at_lo));
                check("a.at_hi", 32'(ifa.at_hi), 32'(o.at_hi));
                check("a.ovf", 32'(ifa.ovf), 32'(o.ovf));
                check("a.unf", 32'(ifa.unf), 32'(o.unf));
                check("a.bus_err", 32'(ifa.bus_err), 32'(o.berr));
                if (o.bus_chk) check("a.abus", 32'(abus_a), o.bus);
            end
        end
        if (qb.size() > 0) begin
            o = qb.pop_front();
            if (o.known) begin
                check("b.sp", 32'(ifb.sp), o.sp);
                check("b.at_lo", 32'(ifb.at_lo), 32'(o.at_lo));
                check("b.at_hi", 32'(ifb.at_hi), 32'(o.at_hi));
                check("b.ovf", 32'(ifb.ovf), 32'(o.ovf));
                check("b.unf", 32'(ifb.unf), 32'(o.unf));
                check("b.bus_err", 32'(ifb.bus_err), 32'(o.berr));
                if (o.bus_chk) check("b.abus", 32'(abus_b), o.bus);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ldv;
        reset = 1; loadn = 1; cupn = 1; cdownn = 1; outn = 1; offsn = 1;
        offset = '0; fault_clr = 0; drv = 0; drv_a = '0; drv_b = '0;
        for (int d = 0; d < 2; d++) begin
            m_known[d] = 0; m_sp[d] = 0; m_lat[d] = 0;
            m_ovf[d] = 0; m_unf[d] = 0; m_berr[d] = 0;
        end

        // Reset, three decrements, then read back
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("rst.sp", 32'(ifa.sp), 32'h0000FFFF);
        check("rst.flags", {29'b0, ifa.ovf, ifa.unf, ifa.bus_err}, 32'h0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000);
        #1 check("dec3.sp", 32'(ifa.sp), 32'h0000FFFC);
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000);
        #1 check("dec3.abus", 32'(abus_a), 32'h0000FFFC);

        // Underflow at LIMIT_LO = 0, then clear
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0002);
        repeat (4) cyc(0, 0, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1, 16'h0000);
        #1 check("unf.sp", 32'(ifa.sp), 32'h0);
        check("unf.set", 32'(ifa.unf), 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("unf.clr", 32'(ifa.unf), 32'h0);

        // Overflow at LIMIT_HI, then both count lines low is a plain hold
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 0, 16'hFFFF);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 1, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("ovf.sp", 32'(ifa.sp), 32'h0000FFFF);
        check("ovf.set", 32'(ifa.ovf), 32'h1);
        check("ovf.no_unf", 32'(ifa.unf), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1, 16'h0000);

        // Offset read-back, negative then positive displacement
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h1000);
        cyc(0, 0, 0, 0, 0, 1, 8'h80, 0, 16'h0000);
        cyc(0, 0, 0, 0, 1, 1, 8'h7F, 0, 16'h0000);
        #1 check("offs.neg", 32'(abus_a), 32'h00000F80);
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000);
        #1 check("offs.pos", 32'(abus_a), 32'h0000107F);

        // Load/output conflict, then reset beats a load
        cyc(0, 1, 0, 0, 1, 0, 8'h00, 0, 16'hABCD);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("conf.sp", 32'(ifa.sp), 32'h00001000);
        check("conf.bus_err", 32'(ifa.bus_err), 32'h1);
        cyc(1, 1, 0, 0, 0, 0, 8'h00, 0, 16'h1234);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("rstld.sp", 32'(ifa.sp), 32'h0000FFFF);
        check("rstld.flags", {29'b0, ifa.ovf, ifa.unf, ifa.bus_err}, 32'h0);

        // Narrow instance: window floor and below-window counting
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0010);
        cyc(0, 0, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("win.hold", 32'(ifb.sp), 32'h10);
        check("win.unf", 32'(ifb.unf), 32'h1);
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 1, 16'h0005);
        cyc(0, 0, 0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        #1 check("win.below", 32'(ifb.sp), 32'h04);
        check("win.no_unf", 32'(ifb.unf), 32'h0);

        // Randomised traffic biased toward limit values
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 7))
                0: ldv = 16'hFFFF;
                1: ldv = 16'hFFFE;
                2: ldv = 16'h0001;
                3: ldv = 16'h0010;
                4: ldv = 16'h00EF;
                5: ldv = 16'h0011;
                default: ldv = 16'($urandom);
            endcase
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                8'($urandom), $urandom_range(0, 9) == 0, ldv);
        end

        cyc(0, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000);
        repeat (3) @(negedge clk);
        check("queue.drain", 32'(qa.size() + qb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
